// File: rtl/l2_cacheline_adaptor.sv
// l2_cacheline_adaptor
//   Converts single 256-bit L2 line reads/writebacks into four 64-bit memory
//   beats (beat 0 = line bits [63:0] first) and reassembles read beats into a
//   full line. Every transaction ends with a one-cycle pmem_resp.
//
// Ports
//   clk, rst          : clock, synchronous active-low reset
//   pmem_read/write   : L2 line request (held until pmem_resp)
//   pmem_address      : L2 line address (low 5 bits dropped)
//   pmem_wdata        : writeback line
//   pmem_rdata        : assembled read line, valid with pmem_resp
//   pmem_resp         : completion pulse
//   burst_rdata       : read beat from memory
//   burst_resp        : beat handshake, one beat per cycle it is high
//   burst_wdata       : write beat to memory
//   burst_read/write  : memory burst request
//   burst_address     : line-aligned burst address, 0 while idle
//
// Build option
//   L2_ADAPTOR_FWD_EN : drop the DONE state; pmem_resp (and, for reads, the
//                       last beat) is forwarded combinationally in the cycle
//                       beat 3 is accepted.
module l2_cacheline_adaptor #(
   parameter int s_line  = 256,
   parameter int s_burst = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pmem_read,
   input  logic               pmem_write,
   input  logic [31:0]        pmem_address,
   input  logic [s_line-1:0]  pmem_wdata,
   output logic [s_line-1:0]  pmem_rdata,
   output logic               pmem_resp,
   input  logic [s_burst-1:0] burst_rdata,
   input  logic               burst_resp,
   output logic [s_burst-1:0] burst_wdata,
   output logic               burst_read,
   output logic               burst_write,
   output logic [31:0]        burst_address
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

`ifdef L2_ADAPTOR_FWD_EN
   localparam logic [1:0] AFTER_LAST = IDLE;
`else
   localparam logic [1:0] AFTER_LAST = DONE;
`endif

   logic [1:0]        state;
   logic [1:0]        cnt;
   logic [s_line-1:0] line_buf;   // writeback line, or read line being filled
   logic [31:0]       addr_q;

   logic last_beat;
   assign last_beat = (cnt == 2'd3) && burst_resp;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= 2'd0;
         line_buf <= '0;
         addr_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               // Write wins if the L2 ever raises both.
               if (pmem_write) begin
                  line_buf <= pmem_wdata;
                  addr_q   <= pmem_address & 32'hFFFF_FFE0;
                  cnt      <= 2'd0;
                  state    <= WRITE;
               end else if (pmem_read) begin
                  addr_q   <= pmem_address & 32'hFFFF_FFE0;
                  cnt      <= 2'd0;
                  state    <= READ;
               end
            end
            READ: begin
               if (burst_resp) begin
                  line_buf[int'(cnt)*s_burst +: s_burst] <= burst_rdata;
                  cnt <= cnt + 2'd1;
                  if (last_beat) state <= AFTER_LAST;
               end
            end
            WRITE: begin
               if (burst_resp) begin
                  cnt <= cnt + 2'd1;
                  if (last_beat) state <= AFTER_LAST;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      burst_read    = (state == READ);
      burst_write   = (state == WRITE);
      burst_wdata   = (state == WRITE) ? line_buf[int'(cnt)*s_burst +: s_burst] : '0;
      burst_address = (state == IDLE) ? '0 : addr_q;
`ifdef L2_ADAPTOR_FWD_EN
      // Beat 3 bypasses the buffer so the line is complete in its accept cycle.
      pmem_resp  = ((state == READ) || (state == WRITE)) && last_beat;
      pmem_rdata = ((state == READ) && (cnt == 2'd3))
                   ? {burst_rdata, line_buf[s_line-s_burst-1:0]} : line_buf;
`else
      pmem_resp  = (state == DONE);
      pmem_rdata = line_buf;
`endif
   end

endmodule
